// File: rtl/gtp_pkg.sv
// Shared types and constants for the GTP tape image loader.
//  gtp_state_t : parser FSM states
//  gtp_err_t   : load_err codes reported to the OSD/LED
//  gtp_wr_t    : one RAM write request {addr, data}
package gtp_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   localparam logic [7:0] GTP_DATA = 8'h00;
   localparam logic [7:0] GTP_NAME = 8'h10;
   localparam logic [7:0] GTP_SYNC = 8'hA5;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HDR,
      ST_SYNC,
      ST_ADDR,
      ST_DATA,
      ST_CSUM,
      ST_SKIP,
      ST_DONE,
      ST_ERR
   } gtp_state_t;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_SYNC     = 3'd1,
      ERR_CSUM     = 3'd2,
      ERR_RANGE    = 3'd3,
      ERR_OVERFLOW = 3'd4,
      ERR_TRUNC    = 3'd5,
      ERR_LENGTH   = 3'd6
   } gtp_err_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } gtp_wr_t;

endpackage

// File: rtl/gtp_wr_skid.sv
// Output register plus 1-entry skid buffer in front of the RAM write port.
//  clk_sys, reset       : clock, async active-high reset
//  push, push_req       : new write request (only issued when accept_c=1)
//  mem_busy             : RAM cannot take the write this cycle
//  mem_wr/addr/dout     : registered write request, held until mem_busy=0
//  accept_c             : a push this cycle can be stored
//  idle_c               : no write pending anywhere
module gtp_wr_skid
   import gtp_pkg::*;
(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        push,
   input  gtp_wr_t     push_req,
   input  logic        mem_busy,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_dout,
   output logic        accept_c,
   output logic        idle_c
);
   gtp_wr_t out_q;
   gtp_wr_t skid_q;
   logic    skid_v;
   logic    out_free_c;

   // Skid is only ever occupied while the output slot is, so full == skid_v && stalled.
   assign accept_c   = !(skid_v && mem_busy);
   assign idle_c     = !mem_wr && !skid_v;
   assign out_free_c = !mem_wr || !mem_busy;
   assign mem_addr   = out_q.addr;
   assign mem_dout   = out_q.data;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         mem_wr <= 1'b0;
         skid_v <= 1'b0;
         out_q  <= '0;
         skid_q <= '0;
      end else if (out_free_c) begin
         if (skid_v) begin
            out_q  <= skid_q;
            mem_wr <= 1'b1;
            skid_v <= push;
            if (push) skid_q <= push_req;
         end else begin
            mem_wr <= push;
            if (push) out_q <= push_req;
         end
      end else if (push && !skid_v) begin
         skid_q <= push_req;
         skid_v <= 1'b1;
      end
   end

endmodule

// File: rtl/gtp_tape_loader.sv
// Parses a GTP tape image streamed from data_io and emits Galaksija RAM writes.
//  clk_sys, reset          : clock, async active-high reset
//  ioctl_download/wr/addr/dout : data_io download stream
//  mem_busy                : RAM write port stall
//  mem_wr/addr/dout        : RAM write request (held while mem_busy)
//  load_busy/done/err      : load status, done/err sticky until next download
//  blocks_loaded           : data blocks with a good checksum
module gtp_tape_loader
   import gtp_pkg::*;
#(
   parameter logic [15:0] RAM_BASE   = 16'h2800,
   parameter logic [15:0] RAM_TOP    = 16'hFFFF,
   parameter logic [7:0]  MAX_BLOCKS = 8'd255
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [26:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic        mem_busy,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_dout,
   output logic        load_busy,
   output logic        load_done,
   output logic [2:0]  load_err,
   output logic [7:0]  blocks_loaded
);
   gtp_state_t  state, state_n;
   gtp_err_t    err_q, err_n;
   logic        dl_q;
   logic [2:0]  step, step_n;
   logic [7:0]  blk_type, blk_type_n;
   logic [31:0] blk_len, blk_len_n, rem, rem_n;
   logic [15:0] start_a, start_n, wr_addr, wr_addr_n;
   logic [7:0]  end_lo, end_lo_n, csum, csum_n;
   logic [26:0] exp_addr, exp_addr_n;
   logic        first_q, first_n;
   logic        busy_n, done_n;
   logic [7:0]  blocks_n;
   logic        push_c, skid_acc_c, skid_idle_c;
   logic        dl_rise_c, dl_fall_c, active_c;
   logic [31:0] len_sh_c;
   logic [15:0] end_c, span_c;
   logic [7:0]  csum_add_c;
   gtp_wr_t     push_req_c;

   assign dl_rise_c  = ioctl_download && !dl_q;
   assign dl_fall_c  = !ioctl_download && dl_q;
   assign active_c   = state inside {ST_HDR, ST_SYNC, ST_ADDR, ST_DATA, ST_CSUM, ST_SKIP};
   assign len_sh_c   = {ioctl_dout, blk_len[31:8]};   // little-endian shift-in
   assign end_c      = {ioctl_dout, end_lo};
   assign span_c     = end_c - start_a;
   assign csum_add_c = csum + ioctl_dout;
   assign push_req_c = '{addr: wr_addr, data: ioctl_dout};
   assign load_err   = err_q;

   gtp_wr_skid u_skid (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .push     (push_c),
      .push_req (push_req_c),
      .mem_busy (mem_busy),
      .mem_wr   (mem_wr),
      .mem_addr (mem_addr),
      .mem_dout (mem_dout),
      .accept_c (skid_acc_c),
      .idle_c   (skid_idle_c)
   );

   // Next-state: byte parsing first, then download edge handling.
   always_comb begin
      state_n    = state;
      err_n      = err_q;
      step_n     = step;
      blk_type_n = blk_type;
      blk_len_n  = blk_len;
      rem_n      = rem;
      start_n    = start_a;
      end_lo_n   = end_lo;
      wr_addr_n  = wr_addr;
      csum_n     = csum;
      exp_addr_n = exp_addr;
      first_n    = first_q;
      busy_n     = load_busy;
      done_n     = load_done;
      blocks_n   = blocks_loaded;
      push_c     = 1'b0;

      if (dl_rise_c) begin
         state_n  = ST_HDR;
         step_n   = 3'd0;
         first_n  = 1'b1;
         busy_n   = 1'b1;
         done_n   = 1'b0;
         err_n    = ERR_NONE;
         blocks_n = 8'd0;
      end else begin
         if (ioctl_wr && active_c) begin
            exp_addr_n = ioctl_addr + 27'd1;
            first_n    = 1'b0;
            if (!first_q && ioctl_addr != exp_addr) begin
               state_n = ST_ERR;
               err_n   = ERR_TRUNC;
            end else begin
               case (state)
                  ST_HDR: begin
                     step_n = step + 3'd1;
                     if (step == 3'd0) blk_type_n = ioctl_dout;
                     else              blk_len_n  = len_sh_c;
                     if (step == 3'd4) begin
                        step_n = 3'd0;
                        // Name blocks, unknown types and data past MAX_BLOCKS are skipped.
                        if (blk_type == GTP_DATA && blocks_loaded != MAX_BLOCKS)
                           state_n = ST_SYNC;
                        else if (len_sh_c == 32'd0)
                           state_n = ST_HDR;
                        else begin
                           state_n = ST_SKIP;
                           rem_n   = len_sh_c;
                        end
                     end
                  end
                  ST_SYNC: begin
                     if (ioctl_dout == GTP_SYNC) begin
                        state_n = ST_ADDR;
                        step_n  = 3'd0;
                        csum_n  = 8'd0;
                     end else begin
                        state_n = ST_ERR;
                        err_n   = ERR_SYNC;
                     end
                  end
                  ST_ADDR: begin
                     csum_n = csum_add_c;
                     step_n = step + 3'd1;
                     case (step)
                        3'd0:    start_n[7:0]  = ioctl_dout;
                        3'd1:    start_n[15:8] = ioctl_dout;
                        3'd2:    end_lo_n      = ioctl_dout;
                        default: begin
                           if (start_a < RAM_BASE || end_c < start_a ||
                               ({1'b0, end_c} - 17'd1) > {1'b0, RAM_TOP}) begin
                              state_n = ST_ERR;
                              err_n   = ERR_RANGE;
                           end else if (blk_len != 32'd6 + 32'(span_c)) begin
                              state_n = ST_ERR;
                              err_n   = ERR_LENGTH;
                           end else begin
                              wr_addr_n = start_a;
                              rem_n     = 32'(span_c);
                              state_n   = (span_c == 16'd0) ? ST_CSUM : ST_DATA;
                           end
                        end
                     endcase
                  end
                  ST_DATA: begin
                     if (!skid_acc_c) begin
                        state_n = ST_ERR;
                        err_n   = ERR_OVERFLOW;
                     end else begin
                        push_c    = 1'b1;
                        csum_n    = csum_add_c;
                        wr_addr_n = wr_addr + 16'd1;
                        rem_n     = rem - 32'd1;
                        if (rem == 32'd1) state_n = ST_CSUM;
                     end
                  end
                  ST_CSUM: begin
                     if (csum_add_c == 8'hFF) begin
                        blocks_n = (blocks_loaded == MAX_BLOCKS) ? blocks_loaded
                                                                 : blocks_loaded + 8'd1;
                        state_n  = ST_HDR;
                        step_n   = 3'd0;
                     end else begin
                        state_n = ST_ERR;
                        err_n   = ERR_CSUM;
                     end
                  end
                  ST_SKIP: begin
                     rem_n = rem - 32'd1;
                     if (rem == 32'd1) begin
                        state_n = ST_HDR;
                        step_n  = 3'd0;
                     end
                  end
                  default: ;
               endcase
            end
         end

         // End of image, judged on the state after any same-cycle byte.
         if (dl_fall_c && state != ST_IDLE && state != ST_DONE) begin
            if (state_n == ST_HDR && step_n == 3'd0) done_n = 1'b1;
            else if (state_n != ST_ERR)              err_n  = ERR_TRUNC;
            state_n = ST_DONE;
         end

         if (state == ST_DONE && skid_idle_c) begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         err_q         <= ERR_NONE;
         dl_q          <= 1'b0;
         step          <= 3'd0;
         blk_type      <= 8'd0;
         blk_len       <= 32'd0;
         rem           <= 32'd0;
         start_a       <= 16'd0;
         end_lo        <= 8'd0;
         wr_addr       <= 16'd0;
         csum          <= 8'd0;
         exp_addr      <= 27'd0;
         first_q       <= 1'b0;
         load_busy     <= 1'b0;
         load_done     <= 1'b0;
         blocks_loaded <= 8'd0;
      end else begin
         state         <= state_n;
         err_q         <= err_n;
         dl_q          <= ioctl_download;
         step          <= step_n;
         blk_type      <= blk_type_n;
         blk_len       <= blk_len_n;
         rem           <= rem_n;
         start_a       <= start_n;
         end_lo        <= end_lo_n;
         wr_addr       <= wr_addr_n;
         csum          <= csum_n;
         exp_addr      <= exp_addr_n;
         first_q       <= first_n;
         load_busy     <= busy_n;
         load_done     <= done_n;
         blocks_loaded <= blocks_n;
      end
   end

endmodule

// File: tb/tb_gtp_tape_loader.sv
// Self-checking bench for gtp_tape_loader: table of images plus hand sequences.
module tb_gtp_tape_loader;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [26:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        mem_busy;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [7:0]  mem_dout;
   logic        load_busy;
   logic        load_done;
   logic [2:0]  load_err;
   logic [7:0]  blocks_loaded;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [23:0] wq[$];

   always #5 clk_sys = ~clk_sys;

   gtp_tape_loader dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .mem_busy       (mem_busy),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_dout       (mem_dout),
      .load_busy      (load_busy),
      .load_done      (load_done),
      .load_err       (load_err),
      .blocks_loaded  (blocks_loaded)
   );

   // Record every write the RAM accepts.
   always @(negedge clk_sys)
      if (!reset && mem_wr && !mem_busy) wq.push_back({mem_addr, mem_dout});

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      string        name;
      logic [319:0] img;
      int unsigned  n;
      logic [143:0] wr;
      int unsigned  nwr;
      logic [7:0]   blk;
      logic         done;
      logic [2:0]   err;
      logic         fall_last;
      int unsigned  gap;
   } vec_t;

   localparam logic [111:0] BLK1  = {8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'hA5,
                                     8'h00, 8'h2C, 8'h03, 8'h2C, 8'h11, 8'h22, 8'h33, 8'h3E};
   localparam logic [71:0]  WR1   = {24'h2C0011, 24'h2C0122, 24'h2C0233};
   localparam logic [71:0]  NAMEB = {8'h10, 8'h04, 8'h00, 8'h00, 8'h00, 8'h50, 8'h52, 8'h4F, 8'h47};
   localparam logic [95:0]  BLK2  = {8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'hA5,
                                     8'h10, 8'h40, 8'h11, 8'h40, 8'h77, 8'hE7};

   vec_t vecs[$];

   function automatic vec_t mk(input string nm, input logic [319:0] img, input int unsigned n,
                               input logic [143:0] wr, input int unsigned nwr, input logic [7:0] blk,
                               input logic done, input logic [2:0] err, input logic fall_last,
                               input int unsigned gap);
      vec_t v;
      v.name = nm; v.img = img; v.n = n; v.wr = wr; v.nwr = nwr; v.blk = blk;
      v.done = done; v.err = err; v.fall_last = fall_last; v.gap = gap;
      return v;
   endfunction

   // Sends one image byte: strobe for one cycle then one idle cycle.
   task automatic send(input logic [7:0] b, input int unsigned a, input logic drop_dl);
      ioctl_wr   = 1'b1;
      ioctl_addr = 27'(a);
      ioctl_dout = b;
      if (drop_dl) ioctl_download = 1'b0;
      @(posedge clk_sys); #1;
      ioctl_wr = 1'b0;
      @(posedge clk_sys); #1;
   endtask

   task automatic start_dl(input string nm);
      wq.delete();
      ioctl_download = 1'b1;
      @(posedge clk_sys); #1;
      chk({nm, ".busy_set"}, 32'(load_busy), 32'd1);
   endtask

   task automatic end_dl(input string nm);
      int unsigned t;
      ioctl_download = 1'b0;
      t = 0;
      while ((load_busy || ioctl_download) && t < 100) begin
         @(posedge clk_sys); #1;
         t++;
      end
      chk({nm, ".busy_clr"}, 32'(load_busy), 32'd0);
   endtask

   task automatic check_result(input vec_t v);
      logic [31:0] act;
      chk({v.name, ".nwr"}, 32'(wq.size()), 32'(v.nwr));
      for (int j = 0; j < int'(v.nwr); j++) begin
         act = (j < wq.size()) ? 32'(wq[j]) : 32'hFFFF_FFFF;
         chk($sformatf("%s.wr%0d", v.name, j), act, 32'(v.wr[24*(v.nwr-1-j) +: 24]));
      end
      chk({v.name, ".blocks"}, 32'(blocks_loaded), 32'(v.blk));
      chk({v.name, ".done"}, 32'(load_done), 32'(v.done));
      chk({v.name, ".err"}, 32'(load_err), 32'(v.err));
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] b;
      int unsigned a;
      start_dl(v.name);
      for (int k = 0; k < int'(v.n); k++) begin
         b = v.img[8*(v.n-1-k) +: 8];
         a = k + ((k >= int'(v.gap)) ? 1 : 0);
         send(b, a, v.fall_last && (k == int'(v.n) - 1));
      end
      end_dl(v.name);
      check_result(v);
   endtask

   initial begin
      vecs.push_back(mk("basic",    320'(BLK1), 14, 144'(WR1), 3, 8'd1, 1'b1, 3'd0, 1'b0, 999));
      vecs.push_back(mk("name",     320'({NAMEB, BLK1}), 23, 144'(WR1), 3, 8'd1, 1'b1, 3'd0, 1'b0, 999));
      vecs.push_back(mk("range_lo", 320'({8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h10,
                                          8'h03, 8'h10, 8'h11, 8'h22, 8'h33, 8'h00}),
                        14, 144'd0, 0, 8'd0, 1'b0, 3'd3, 1'b0, 999));
      vecs.push_back(mk("csum_bad", 320'({BLK1[111:8], 8'h3F}), 14, 144'(WR1), 3, 8'd0, 1'b0, 3'd2, 1'b0, 999));
      vecs.push_back(mk("trunc",    320'(BLK1[111:16]), 12, 144'(WR1[71:24]), 2, 8'd0, 1'b0, 3'd5, 1'b0, 999));
      vecs.push_back(mk("empty",    320'({8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h30,
                                          8'h00, 8'h30, 8'h9F}), 11, 144'd0, 0, 8'd1, 1'b1, 3'd0, 1'b0, 999));
      vecs.push_back(mk("len_bad",  320'({8'h00, 8'h0A, BLK1[95:0]}), 14, 144'd0, 0, 8'd0, 1'b0, 3'd6, 1'b0, 999));
      vecs.push_back(mk("sync_bad", 320'({BLK1[111:72], 8'hA6, BLK1[63:0]}), 14, 144'd0, 0, 8'd0, 1'b0, 3'd1, 1'b0, 999));
      vecs.push_back(mk("skip_unk", 320'({8'h55, 8'h02, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, BLK1}),
                        21, 144'(WR1), 3, 8'd1, 1'b1, 3'd0, 1'b0, 999));
      vecs.push_back(mk("two_blk",  320'({BLK1, BLK2}), 26, 144'({WR1, 24'h401077}), 4, 8'd2, 1'b1, 3'd0, 1'b0, 999));
      vecs.push_back(mk("end_lt_st", 320'({8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hF0, 8'hFF,
                                           8'h00, 8'h00, 8'h00}), 11, 144'd0, 0, 8'd0, 1'b0, 3'd3, 1'b0, 999));
      vecs.push_back(mk("fall_wr",  320'(BLK1), 14, 144'(WR1), 3, 8'd1, 1'b1, 3'd0, 1'b1, 999));
      vecs.push_back(mk("hdr_part", 320'({8'h00, 8'h09}), 2, 144'd0, 0, 8'd0, 1'b0, 3'd5, 1'b0, 999));
      vecs.push_back(mk("addr_gap", 320'(BLK1), 14, 144'd0, 0, 8'd0, 1'b0, 3'd5, 1'b0, 8));

      reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
      ioctl_addr = 27'd0; ioctl_dout = 8'd0; mem_busy = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("rst.mem_wr", 32'(mem_wr), 32'd0);
      chk("rst.mem_addr", 32'(mem_addr), 32'd0);
      chk("rst.mem_dout", 32'(mem_dout), 32'd0);
      chk("rst.busy", 32'(load_busy), 32'd0);
      chk("rst.done", 32'(load_done), 32'd0);
      chk("rst.err", 32'(load_err), 32'd0);
      chk("rst.blocks", 32'(blocks_loaded), 32'd0);
      reset = 1'b0;
      @(posedge clk_sys); #1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // RAM stalled during DATA: first byte held, second skidded, third overflows.
      start_dl("ovf");
      for (int k = 0; k < 10; k++) send(BLK1[8*(13-k) +: 8], k, 1'b0);
      mem_busy = 1'b1;
      for (int k = 10; k < 13; k++) send(BLK1[8*(13-k) +: 8], k, 1'b0);
      chk("ovf.err", 32'(load_err), 32'd4);
      chk("ovf.mem_wr", 32'(mem_wr), 32'd1);
      chk("ovf.held", 32'({mem_addr, mem_dout}), 32'h2C0011);
      repeat (14) @(posedge clk_sys);
      #1;
      mem_busy = 1'b0;
      send(8'h3E, 13, 1'b0);
      end_dl("ovf");
      check_result(mk("ovf", 320'd0, 0, 144'(WR1[71:24]), 2, 8'd0, 1'b0, 3'd4, 1'b0, 999));

      // Reset with a write stuck behind mem_busy, then a clean reload.
      mem_busy = 1'b1;
      start_dl("rstwr");
      for (int k = 0; k < 11; k++) send(BLK1[8*(13-k) +: 8], k, 1'b0);
      chk("rstwr.pending", 32'(mem_wr), 32'd1);
      reset = 1'b1;
      ioctl_download = 1'b0;
      @(posedge clk_sys); #1;
      chk("rstwr.mem_wr", 32'(mem_wr), 32'd0);
      chk("rstwr.busy", 32'(load_busy), 32'd0);
      reset = 1'b0;
      mem_busy = 1'b0;
      @(posedge clk_sys); #1;
      run_vec(mk("reload", 320'(BLK1), 14, 144'(WR1), 3, 8'd1, 1'b1, 3'd0, 1'b0, 999));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
